// File: rtl/vita49_trig_pkg.sv
// Shared definitions for the VITA49 timed sample gate: FSM state encoding and
// ctrl/status register bit positions.
package vita49_trig_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam int CTRL_ARM   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_IMM   = 2;
   localparam int CTRL_ABORT = 3;

   localparam int STAT_LATE    = 2;
   localparam int STAT_DONE    = 3;
   localparam int STAT_ABORTED = 4;

endpackage

// File: rtl/vita49_trig_framer.sv
// Sample/packet counters of the VITA49 trigger: forwards gated samples with one
// cycle of latency and marks sop/eop/out_tsf for fixed-length packets.
module vita49_trig_framer
#(
   parameter int DATA_W  = 32,
   parameter int PKT_LEN = 256,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              run,
   input  logic              continuous,
   input  logic [CNT_W-1:0]  burst_len,
   input  logic [63:0]       tsf,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sop,
   output logic              out_eop,
   output logic [63:0]       out_tsf,
   output logic              pkt_open,
   output logic              burst_end
);

   localparam int IDX_W = $clog2(PKT_LEN);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] pkt_idx;
   logic             accept;
   logic             last;
   logic             sop;
   logic             eop;

   // The sample counter never passes burst_len, so != is the remaining-samples test.
   assign accept    = run && in_valid && (continuous || (cnt != burst_len));
   assign last      = !continuous && (cnt == burst_len - CNT_W'(1));
   assign sop       = (pkt_idx == '0);
   assign eop       = (pkt_idx == IDX_LAST) || last;
   assign pkt_open  = (pkt_idx != '0);
   assign burst_end = run && !continuous && ((cnt == burst_len) || (accept && last));

   // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_tsf   <= '0;
         cnt       <= '0;
         pkt_idx   <= '0;
      end else begin
         out_valid <= accept;
         out_sop   <= accept && sop;
         out_eop   <= accept && eop;
         if (accept) begin
            out_data <= in_data;
            if (sop) out_tsf <= tsf;
            cnt     <= cnt + CNT_W'(1);
            pkt_idx <= eop ? '0 : pkt_idx + IDX_W'(1);
         end else if (clear) begin
            cnt     <= '0;
            pkt_idx <= '0;
         end
      end
   end

endmodule

// File: rtl/vita49_trigger.sv
// Timed sample gate: arms on a tsf trigger and passes a burst of samples as packets.
// Optional periodic re-arm is built when VITA49_TRIG_PERIODIC_EN is defined.
module vita49_trigger
   import vita49_trig_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int PKT_LEN = 256,
   parameter int CNT_W   = 32
) (
   input  logic              samp_clk,
   input  logic              ARESET,
   input  logic [31:0]       ctrl,
   input  logic [63:0]       trig_tsf,
   input  logic [63:0]       trig_period,
   input  logic [CNT_W-1:0]  burst_len,
   input  logic [63:0]       tsf,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sop,
   output logic              out_eop,
   output logic [63:0]       out_tsf,
   output logic              out_abort,
   output logic [31:0]       status
);

   state_t           state, state_nxt;
   logic [63:0]      trig_l;
   logic [CNT_W-1:0] blen_l;
   logic             cont_l;
   logic             arm_q, arm_qq;
   logic             late, done, aborted;
   logic             abort, arm_edge, fire, gate;
   logic             burst_end, pkt_open;
   logic             load, set_late, set_done, abort_pulse;
   logic             unused;
`ifdef VITA49_TRIG_PERIODIC_EN
   logic             rearm;
   logic [63:0]      next_trig;
   assign next_trig = trig_l + trig_period;
`endif

   assign abort    = ctrl[CTRL_ABORT];
   assign arm_edge = arm_q && !arm_qq;
   assign fire     = (state == ST_ARMED) && (tsf >= trig_l);
   assign gate     = !abort && ((state == ST_RUN) || fire);
   assign status   = {27'd0, aborted, done, late, state};
   assign unused   = ^{ctrl[31:4], trig_period};

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      load        = 1'b0;
      set_late    = 1'b0;
      set_done    = 1'b0;
      abort_pulse = 1'b0;
`ifdef VITA49_TRIG_PERIODIC_EN
      rearm       = 1'b0;
`endif
      if (abort) begin
         state_nxt   = ST_IDLE;
         abort_pulse = pkt_open;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arm_edge) begin
                  load = 1'b1;
                  if (ctrl[CTRL_IMM])     state_nxt = ST_RUN;
                  else if (trig_tsf <= tsf) set_late = 1'b1;
                  else                    state_nxt = ST_ARMED;
               end
            end
            ST_ARMED: if (fire) state_nxt = ST_RUN;
            ST_RUN:   ;
            default:  state_nxt = ST_IDLE;
         endcase
         if (gate && burst_end) begin
            set_done  = 1'b1;
            state_nxt = ST_IDLE;
`ifdef VITA49_TRIG_PERIODIC_EN
            if (trig_period != '0) begin
               rearm = 1'b1;
               if (next_trig <= tsf) set_late  = 1'b1;
               else                  state_nxt = ST_ARMED;
            end
`endif
         end
      end
   end

   always_ff @(posedge samp_clk or posedge ARESET) begin
      if (ARESET) begin
         state     <= ST_IDLE;
         trig_l    <= '0;
         blen_l    <= '0;
         cont_l    <= 1'b0;
         arm_q     <= 1'b0;
         arm_qq    <= 1'b0;
         late      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         out_abort <= 1'b0;
      end else begin
         arm_q     <= ctrl[CTRL_ARM];
         arm_qq    <= arm_q;
         state     <= state_nxt;
         out_abort <= abort_pulse;
         if (load) begin
            trig_l  <= trig_tsf;
            blen_l  <= burst_len;
            cont_l  <= ctrl[CTRL_CONT];
            late    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
         end
`ifdef VITA49_TRIG_PERIODIC_EN
         if (rearm) trig_l <= next_trig;
`endif
         if (set_late) late    <= 1'b1;
         if (set_done) done    <= 1'b1;
         if (abort)    aborted <= 1'b1;
      end
   end

   vita49_trig_framer #(
      .DATA_W  (DATA_W),
      .PKT_LEN (PKT_LEN),
      .CNT_W   (CNT_W)
   ) u_framer (
      .clk        (samp_clk),
      .rst        (ARESET),
      .clear      (!gate),
      .run        (gate),
      .continuous (cont_l),
      .burst_len  (blen_l),
      .tsf        (tsf),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .out_tsf    (out_tsf),
      .pkt_open   (pkt_open),
      .burst_end  (burst_end)
   );

endmodule
